// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets within the two-word window and STATUS bit positions.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [2:0] TXDATA_OFF = 3'd0;
   localparam logic [2:0] STATUS_OFF = 3'd4;

   localparam int BUSY  = 0;
   localparam int FULL  = 1;
   localparam int EMPTY = 2;
   localparam int OVF   = 3;

   function automatic logic [31:0] status_word(input logic ovf,
                                               input logic empty,
                                               input logic full,
                                               input logic busy);
      logic [31:0] w;
      w        = '0;
      w[OVF]   = ovf;
      w[EMPTY] = empty;
      w[FULL]  = full;
      w[BUSY]  = busy;
      return w;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO. A push into a full FIFO is still taken when a pop happens
// on the same edge, because the slot being written is the one being vacated.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the CPU data-memory port:
// TXDATA writes feed a byte FIFO, STATUS reports busy/full/empty/overflow.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        tx
);

   localparam int            BW        = $clog2(CLKS_PER_BIT);
   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    bitc;
   logic [7:0]    sh;
   logic          ovf;

   logic          sel_status;
   logic          wr_txdata;
   logic          wr_status;
   logic          baud_done;
   logic          pop;
   logic          busy;
   logic [7:0]    fifo_dout;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          unused_bits;

   // Low address bits, the upper store byte and the raw count carry no meaning here.
   assign unused_bits = ^{addr[1:0], wdata[31:8], count};

   assign hit        = (addr[31:3] == BASE_ADDR[31:3]);
   assign sel_status = ({addr[2], 2'b00} == STATUS_OFF);
   assign wr_txdata  = hit & we & ({addr[2], 2'b00} == TXDATA_OFF);
   assign wr_status  = hit & we & sel_status;

   assign baud_done = (baud == BAUD_LAST);
   assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
   assign busy      = (state != IDLE) | ~empty;

   always_comb begin
      rdata = '0;
      if (hit && sel_status) begin
         rdata = status_word(ovf, empty, full, busy);
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_txdata),
      .din   (wdata[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Setting wins over clearing if both ever coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (wr_txdata & full & ~pop) begin
         ovf <= 1'b1;
      end else if (wr_status & wdata[OVF]) begin
         ovf <= 1'b0;
      end
   end

   // tx is registered and always reflects the bit of the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         tx    <= 1'b1;
         baud  <= '0;
         bitc  <= '0;
         sh    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!empty) begin
                  sh    <= fifo_dout;
                  baud  <= '0;
                  state <= START;
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (baud_done) begin
                  baud  <= '0;
                  bitc  <= '0;
                  state <= DATA;
                  tx    <= sh[0];
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud <= '0;
                  sh   <= sh >> 1;
                  if (bitc == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bitc <= bitc + 3'd1;
                     tx   <= sh[1];
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud <= '0;
                  if (!empty) begin
                     sh    <= fifo_dout;
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: stimulus queues expected bytes, a serial-line
// monitor decodes every frame on tx and checks it against that queue.
module tb_mmio_uart_tx;

   localparam int          CPB  = 4;
   localparam int          FLEN = 10 * CPB;
   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic        we    = 1'b0;
   logic [31:0] rdata;
   logic        hit;
   logic        tx;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .rdata (rdata),
      .hit   (hit),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         errors    = 0;
   int         checks    = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];
   int         frame_cnt = 0;
   bit         mon_act   = 0;
   int         mon_idx   = 0;
   logic [9:0] mon_bits  = '0;
   bit         glitch    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Serial monitor: one negedge sample per clock, every sample of a bit must agree.
   always @(negedge clk) begin
      if (reset) begin
         mon_act = 0;
      end else begin
         if (!mon_act && tx === 1'b0) begin
            mon_act = 1;
            mon_idx = 0;
            glitch  = 0;
            frame_cnt++;
            start_q.push_back(cyc);
         end
         if (mon_act) begin
            if (mon_idx % CPB == 0) mon_bits[mon_idx / CPB] = tx;
            else if (tx !== mon_bits[mon_idx / CPB]) glitch = 1;
            if (mon_idx == FLEN - 1) begin
               chk("frame_shape", {29'd0, glitch, mon_bits[9], mon_bits[0]}, 32'b010);
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", {24'd0, mon_bits[8:1]}, 32'hFFFF_FFFF);
               end else begin
                  chk("frame_data", {24'd0, mon_bits[8:1]}, {24'd0, exp_q.pop_front()});
               end
               mon_act = 0;
            end else begin
               mon_idx++;
            end
         end
      end
   end

   task automatic wr_now(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we   = 1'b0;
      addr = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_now(a, d);
   endtask

   task automatic rd_now(output logic [31:0] v);
      addr = BASE + 32'd4;
      we   = 1'b0;
      #1;
      v    = rdata;
      addr = '0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_start(output int s);
      int n;
      n = 0;
      while (start_q.size() == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (start_q.size() == 0) begin
         chk("frame_start_timeout", 32'd0, 32'd1);
         s = -1000;
      end else begin
         s = start_q.pop_front();
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_act) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int          w;
      int          s;
      int          s2;
      int          fc;

      // Reset and idle decode
      repeat (3) @(posedge clk);
      #1 chk("reset_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      rd_now(v);
      chk("idle_status", v, 32'h4);
      addr = 32'h0000_0010;
      #1 chk("miss_hit", {31'd0, hit}, 32'd0);
      chk("miss_rdata", rdata, 32'd0);
      addr = BASE;
      #1 chk("txdata_hit", {31'd0, hit}, 32'd1);
      chk("txdata_read", rdata, 32'd0);
      addr = BASE + 32'd7;
      #1 chk("status_lowbits", rdata, 32'h4);
      addr = BASE + 32'd8;
      #1 chk("above_window_hit", {31'd0, hit}, 32'd0);
      addr = '0;

      // Single byte 0x55
      start_q.delete();
      wr(BASE, 32'hABCD_EF55);
      w = cyc;
      exp_q.push_back(8'h55);
      wait_start(s);
      chk("single_latency", s, w + 1);
      wait_cyc(s + 20);
      rd_now(v);
      chk("single_busy_mid", v, 32'h5);
      wait_cyc(s + FLEN - 1);
      rd_now(v);
      chk("single_busy_last", v, 32'h5);
      wait_cyc(s + FLEN);
      rd_now(v);
      chk("single_idle_after", v, 32'h4);
      chk("single_tx_idle", {31'd0, tx}, 32'd1);

      // Back-to-back 0x01, 0x80
      repeat (5) @(negedge clk);
      start_q.delete();
      wr(BASE, 32'h01);
      w = cyc;
      wr(BASE, 32'h80);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      wait_start(s);
      chk("b2b_latency", s, w + 1);
      wait_start(s2);
      chk("b2b_no_gap", s2, s + FLEN);
      wait_cyc(s + 2 * FLEN - 1);
      rd_now(v);
      chk("b2b_busy_last", v, 32'h5);
      wait_cyc(s + 2 * FLEN);
      rd_now(v);
      chk("b2b_idle_80", v, 32'h4);

      // Overflow: five accepted, sixth dropped
      repeat (5) @(negedge clk);
      start_q.delete();
      wr(BASE, 32'h3C);
      w = cyc;
      wr(BASE, 32'hA5);
      wr(BASE, 32'h0F);
      wr(BASE, 32'hF0);
      wr(BASE, 32'h96);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h96);
      wr(BASE, 32'hE7);
      @(negedge clk);
      rd_now(v);
      chk("ovf_status", v, 32'hB);
      wr(BASE + 32'd4, 32'h7);
      @(negedge clk);
      rd_now(v);
      chk("ovf_noclear", v, 32'hB);
      wr(BASE + 32'd4, 32'h8);
      @(negedge clk);
      rd_now(v);
      chk("ovf_cleared", v, 32'h3);

      // Push on the exact pop edge of a full FIFO
      wait_start(s);
      chk("ovf_first_start", s, w + 1);
      wait_cyc(s + FLEN - 1);
      wr_now(BASE, 32'h69);
      exp_q.push_back(8'h69);
      @(negedge clk);
      rd_now(v);
      chk("fullpop_status", v, 32'h3);
      wait_idle(600);
      @(negedge clk);
      rd_now(v);
      chk("fullpop_idle", v, 32'h4);

      // Reset during data bit 3 of 0xC3
      repeat (5) @(negedge clk);
      start_q.delete();
      wr(BASE, 32'hC3);
      exp_q.push_back(8'hC3);
      wait_start(s);
      wait_cyc(s + CPB * 4 + 1);
      chk("rst_bit3_low", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      exp_q.delete();
      #1 chk("rst_async_tx", {31'd0, tx}, 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rd_now(v);
      chk("rst_status", v, 32'h4);
      fc = frame_cnt;
      repeat (100) @(negedge clk);
      chk("rst_no_frames", frame_cnt, fc);
      chk("rst_tx_idle", {31'd0, tx}, 32'd1);
      chk("final_queue", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the CPU's store path.
- Decodes `addr`/`we`/`wdata`, which are the same signals that drive `dMem`: the ALU result as the address, `rd2` as the write data.
- Accepted bytes are buffered in a small FIFO and serialised 8N1, LSB first, on `tx`.
- A status register is readable; the top level muxes `rdata` into the register write-back when `hit`=1.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 2-word register window.
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  data address from the CPU (ALU result).
- wdata  in  32  store data from the CPU (`rd2`).
- we  in  1  data-memory write enable.
- rdata  out  32  read data for the addressed register; combinational.
- hit  out  1  `addr` lies in the window; combinational.
- tx  out  1  serial output; registered; idles high.

Behaviour:
- Address decode:
  - `hit` = (addr[31:3] == BASE_ADDR[31:3]).
  - addr[1:0] is ignored.
  - addr[2] selects the register: 0 = TXDATA, 1 = STATUS.
- TXDATA write (hit & we & ~addr[2]) pushes wdata[7:0]; wdata[31:8] is ignored. A TXDATA read returns 0.
- STATUS read returns {28'b0, ovf, empty, full, busy}:
  - busy = (state != IDLE) | ~empty.
  - full = (count == FIFO_DEPTH).
  - empty = (count == 0).
- STATUS write with wdata[3]=1 clears ovf. wdata[3]=0 has no effect.
- When hit=0, rdata = 0.
- Push/pop arbitration:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. In the simultaneous case count is unchanged.
  - A push to a full FIFO with no simultaneous pop is dropped and sets sticky ovf.
  - If an ovf set and a STATUS clear occur in the same cycle (impossible from one port), set wins.
- FSM states IDLE, START, DATA, STOP; a bit counter `bitc` (3 bits); a baud counter `baud` (0..CLKS_PER_BIT-1).
  - IDLE: tx=1. If the FIFO is non-empty, pop into shift register `sh`, go to START, baud=0. tx falls on that same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bitc=0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift `sh` right and increment bitc. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Latency: a TXDATA write at edge N into an empty FIFO with the FSM in IDLE gives count=1 after N. The pop occurs at edge N+1, so tx is low from edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles from the tx fall to the end of the stop bit.
- Reset (asynchronous, at any time including mid-frame):
  - state=IDLE, tx=1, count=0, read/write pointers=0, ovf=0, baud=0, bitc=0, sh=0.
  - A partial frame is abandoned and tx returns high immediately.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package `uart_pkg`:
  - state typedef/localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - register offsets (TXDATA_OFF=0, STATUS_OFF=4);
  - STATUS bit indices (BUSY=0, FULL=1, EMPTY=2, OVF=3).
- One sub-module `byte_fifo`:
  - parameter DEPTH;
  - ports clk, reset, push, din[7:0], pop, dout[7:0], full, empty, count;
  - synchronous push/pop, with the simultaneous-push-when-full rule implemented inside it.

Test Plan:
- Reset then idle: reset=1 for 3 cycles, then release. Expect tx=1, STATUS read = 32'h4 (empty only), hit=0 for addr 32'h0000_0010.
- Single byte: CLKS_PER_BIT=4, write 32'hABCD_EF55 to BASE. Expect tx low starting one edge after the write for 4 cycles, then bits 1,0,1,0,1,0,1,0 (0x55 LSB first) at 4 cycles each, then high for 4 cycles. busy=1 during the frame and 0 after.
- Back-to-back: write 8'h01 then 8'h80 on consecutive cycles. Expect two frames with no idle cycle between the stop bit of 0x01 and the start bit of 0x80; total 80 cycles at CLKS_PER_BIT=4.
- Overflow:
  - With the FSM busy, write 5 bytes to an FIFO_DEPTH=4 FIFO that is empty at the start. The first pop empties one slot, so all are accepted. Then write until full plus one more. Expect STATUS = 32'hB (ovf|full|busy) and the extra byte never transmitted.
  - Write STATUS with 32'h8. Expect ovf=0.
- Full with simultaneous pop: with FIFO full and the FSM ending STOP, write on the exact pop cycle. Expect the byte accepted, count unchanged at 4, ovf=0.
- Reset mid-frame: assert reset during DATA bit 3. Expect tx=1 asynchronously, STATUS = 32'h4 after release, and no further transmission.
